// File: rtl/ysyx_23060208_pkg.sv
// Shared constants and the state type for the instruction SRAM responder.
package ysyx_23060208_pkg;

    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } isram_state_e;

endpackage

// File: rtl/ysyx_23060208_isram_addr_chk.sv
// Maps a byte address to a word index in the array and flags misaligned or
// out-of-range addresses (addresses below BASE wrap to large offsets).
module ysyx_23060208_isram_addr_chk
    import ysyx_23060208_pkg::*;
#(
    parameter int          AW    = INST_W,
    parameter logic [AW-1:0] BASE = RESET_VECTOR,
    parameter int          DEPTH = 1024,
    localparam int         IDX_W = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr,
    output logic [IDX_W-1:0] idx,
    output logic             err
);

    logic [AW-1:0] off;

    // DEPTH is a power of two, so any set bit above the index field is out of range.
    always_comb begin
        off = addr - BASE;
        idx = off[IDX_W+1:2];
        err = (|off[1:0]) || (|off[AW-1:IDX_W+2]);
    end

endmodule

// File: rtl/ysyx_23060208_isram.sv
// Instruction SRAM responder: one fetch in flight, response after LATENCY
// cycles on a valid/ready channel, plus a word-wide load port for images.
module ysyx_23060208_isram
    import ysyx_23060208_pkg::*;
#(
    parameter int                     DATA_WIDTH = INST_W,
    parameter int                     DEPTH      = 1024,
    parameter logic [DATA_WIDTH-1:0]  BASE       = RESET_VECTOR,
    parameter int                     LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a transfer happens on any rising edge where valid && ready;
    // req_ready depends on state only, and rsp_data/rsp_err hold while
    // rsp_valid is high and rsp_ready is low.

    isram_state_e          state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic [IDX_W-1:0] ld_idx;
    logic             ld_err;

    ysyx_23060208_isram_addr_chk #(
        .AW(DATA_WIDTH), .BASE(BASE), .DEPTH(DEPTH)
    ) u_req_chk (
        .addr(req_addr), .idx(req_idx), .err(req_err)
    );

    ysyx_23060208_isram_addr_chk #(
        .AW(DATA_WIDTH), .BASE(BASE), .DEPTH(DEPTH)
    ) u_ld_chk (
        .addr(ld_addr), .idx(ld_idx), .err(ld_err)
    );

    assign req_ready = (state == IDLE);

    // The array survives reset; bad load addresses are silently dropped.
    always_ff @(posedge clk) begin
        if (ld_en && !ld_err) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Reads the pre-edge word, so a same-cycle load is not seen.
                        rsp_data <= req_err ? '0 : mem[req_idx];
                        rsp_err  <= req_err;
                        cnt      <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
